// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM encoding and
// stream framing constants.
package inst_mem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERR
    } state_t;

    localparam int LEN_W          = 16;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 8 * BYTES_PER_WORD;

    // States in which the loader is consuming the byte stream.
    function automatic logic is_busy(input state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CHECK);
    endfunction

endpackage

// File: rtl/inst_mem_loader_word_assembler.sv
// Packs a byte stream into big-endian words; the word is presented together
// with the pulse on the strobe that carries its final byte.
module word_assembler
    import inst_mem_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              byte_stb_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_done_o
);

    localparam int SH_W = WORD_W - 8;

    logic [SH_W-1:0] sh_q;
    logic [1:0]      cnt_q;

    // The earlier bytes sit in the shift register; the last byte joins from
    // the input so the word is complete in the same cycle as its strobe.
    assign word_o      = {sh_q, byte_i};
    assign word_done_o = byte_stb_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (byte_stb_i) begin
            sh_q  <= {sh_q[SH_W-9:0], byte_i};
            cnt_q <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Streams a length-prefixed, checksummed program image into instruction memory
// and releases the CPU only once the whole image has been verified.
module inst_mem_loader #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = inst_mem_loader_pkg::LEN_W
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        cpu_start_o,
    output logic        busy_o,
    output logic        err_o
);

    import inst_mem_loader_pkg::*;

    localparam int          IDX_W    = ADDR_W + 1;
    localparam int unsigned CAPACITY = 2 ** ADDR_W;

    state_t state_q, state_d;

    logic              busy;
    logic              xfer;
    logic              data_stb;
    logic              start_load;
    logic              word_done;
    logic              last_word;
    logic [WORD_W-1:0] asm_word;

    logic [7:0]        len_hi_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_next;
    logic [IDX_W-1:0]  idx_q;
    logic [7:0]        acc_q;

    logic              vld_p1;
    logic [31:0]       addr_p1;
    logic [31:0]       data_p1;

    assign busy       = is_busy(state_q);
    assign xfer       = byte_valid_i && busy;
    assign data_stb   = xfer && (state_q == DATA);
    assign start_load = load_i && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
    assign len_next   = LEN_W'({len_hi_q, byte_data_i});
    assign last_word  = word_done && ((LEN_W'(idx_q) + LEN_W'(1)) == len_q);

    word_assembler u_word_assembler (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (start_load),
        .byte_stb_i  (data_stb),
        .byte_i      (byte_data_i),
        .word_o      (asm_word),
        .word_done_o (word_done)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The last word moves to CHECK on its 4th byte, so the checksum byte can
    // already transfer during that word's write cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (load_i) state_d = LEN_HI;
            end
            LEN_HI: begin
                if (xfer) state_d = LEN_LO;
            end
            LEN_LO: begin
                if (xfer) begin
                    if (32'(len_next) > CAPACITY) begin
                        state_d = ERR;
                    end else if (len_next == '0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (last_word) state_d = CHECK;
            end
            CHECK: begin
                if (xfer) state_d = (byte_data_i == acc_q) ? DONE : ERR;
            end
            DONE, ERR: begin
                if (load_i) state_d = LEN_HI;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: stream capture (length, checksum accumulator, word index).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_hi_q <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
        end else begin
            if (start_load) begin
                len_hi_q <= '0;
                len_q    <= '0;
                idx_q    <= '0;
                acc_q    <= '0;
            end
            if (xfer && (state_q == LEN_HI)) len_hi_q <= byte_data_i;
            if (xfer && (state_q == LEN_LO)) len_q    <= len_next;
            if (data_stb)                    acc_q    <= acc_q ^ byte_data_i;
            if (word_done)                   idx_q    <= idx_q + IDX_W'(1);
        end
    end

    // Stage p1: memory write port; address and data hold between strobes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= word_done;
            if (word_done) begin
                addr_p1 <= {{(32 - IDX_W - 2){1'b0}}, idx_q, 2'b00};
                data_p1 <= asm_word;
            end
        end
    end

    assign byte_ready_o = busy;
    assign busy_o       = busy;
    assign mem_we_o     = vld_p1;
    assign mem_addr_o   = addr_p1;
    assign mem_data_o   = data_p1;
    assign cpu_start_o  = (state_q == DONE);
    assign err_o        = (state_q == ERR);

endmodule
